// File: rtl/uop_sequencer.sv
// Microcode sequencer: fetches 20-bit words from a registered-read program ROM,
// issues datapath operations one at a time and predicates words on a CMP flag.
module uop_sequencer #(
  parameter logic [4:0] OPCODE_RDY          = 5'd0,
  parameter logic [4:0] OPCODE_CMP          = 5'd1,
  parameter logic [2:0] UOP_EXEC_ALWAYS     = 3'd0,
  parameter logic [2:0] UOP_EXEC_PZT1T2_0XX = 3'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  output logic        rdy,
  output logic        err,
  output logic [5:0]  rom_addr,
  input  logic [19:0] rom_data,
  output logic        op_ena,
  output logic [4:0]  op_code,
  output logic [3:0]  op_src1,
  output logic [3:0]  op_src2,
  output logic [3:0]  op_dst,
  input  logic        op_rdy,
  input  logic        op_cmp_eq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic       cond_flag;
  logic       start;
  logic       load;
  logic       advance;
  logic       finish;
  logic       wrap;
  logic       exec_taken;

  logic [4:0] rom_opcode;
  logic [2:0] rom_exec;

  assign rom_opcode = rom_data[19:15];
  assign rom_exec   = rom_data[2:0];

  // Unknown exec codes fall through to "not taken", i.e. the word is skipped.
  assign exec_taken = (rom_exec == UOP_EXEC_ALWAYS) ||
                      ((rom_exec == UOP_EXEC_PZT1T2_0XX) && cond_flag);

  assign op_ena = (state == S_ISSUE);

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    load       = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (ena) begin
          start      = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        load = 1'b1;
        if (rom_opcode == OPCODE_RDY) begin
          finish     = 1'b1;
          state_next = S_DONE;
        end else if (exec_taken) begin
          state_next = S_ISSUE;
        end else begin
          advance = 1'b1;
        end
      end
      S_ISSUE:  state_next = S_WAIT;
      S_WAIT:   advance = op_rdy;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
    wrap = advance && (rom_addr == 6'd63);
    if (advance) state_next = wrap ? S_DONE : S_FETCH;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rdy       <= 1'b1;
      err       <= 1'b0;
      rom_addr  <= 6'd0;
      cond_flag <= 1'b0;
      op_code   <= 5'd0;
      op_src1   <= 4'd0;
      op_src2   <= 4'd0;
      op_dst    <= 4'd0;
    end else begin
      state <= state_next;
      if (start) begin
        rom_addr  <= 6'd0;
        cond_flag <= 1'b0;
        err       <= 1'b0;
        rdy       <= 1'b0;
      end
      if (advance && !wrap) rom_addr <= rom_addr + 6'd1;
      if (wrap) begin
        err <= 1'b1;
        rdy <= 1'b1;
      end
      if (finish) rdy <= 1'b1;
      // Fields stay registered from DECODE until the next DECODE, which keeps
      // them stable for the whole lifetime of an issued operation.
      if (load) begin
        op_code <= rom_data[19:15];
        op_src1 <= rom_data[14:11];
        op_src2 <= rom_data[10:7];
        op_dst  <= rom_data[6:3];
      end
      if ((state == S_WAIT) && op_rdy && (op_code == OPCODE_CMP))
        cond_flag <= op_cmp_eq;
    end
  end

endmodule
